// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
//
// Round-robin arbiter for a shared 4:1 single-bit multiplexer. One requester
// owns the mux at a time. The owner's index drives the mux select lines
// {address1,address0}. A hold limit forces a handoff when an owner has held the
// grant for MAX_HOLD consecutive cycles while another requester is waiting.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles under contention (1..15)
//
// Ports
//   clk                in   rising-edge clock
//   reset_n            in   synchronous active-low reset
//   req0..req3         in   request from requester i, held while access wanted
//   grant0..grant3     out  registered, one-hot or all-zero ownership
//   address0/address1  out  registered mux select = owner index
//   busy               out  registered, high while any grant is high
// -----------------------------------------------------------------------------
module mux_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  output logic grant0,
  output logic grant1,
  output logic grant2,
  output logic grant3,
  output logic address0,
  output logic address1,
  output logic busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t      state_q,    state_d;
  logic [1:0]  owner_q,    owner_d;
  logic [1:0]  last_q,     last_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]  grant_q,    grant_d;
  logic        busy_q,     busy_d;

  logic [3:0]  req;
  logic [3:0]  owner_oh;
  logic [3:0]  others;
  logic [2:0]  pick_all;
  logic [2:0]  pick_others;

  assign req      = {req3, req2, req1, req0};
  assign owner_oh = 4'b0001 << owner_q;
  // Every request except the current owner's. Used both for release and for
  // forced handoff: the owner is always scanned last (last == owner in GRANT),
  // so masking it out is exactly the "pick excludes the owner" rule.
  assign others   = req & ~owner_oh;

  // Round-robin scan starting one past 'from'. Returns {found, index}.
  // The loop runs from the farthest offset to the nearest so the nearest
  // requesting index is the last assignment and therefore wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand,
                                         input logic [1:0] from);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = from + 2'(k);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign pick_all    = rr_pick(req,    last_q);
  assign pick_others = rr_pick(others, last_q);

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;

    unique case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          state_d    = GRANT;
          owner_d    = pick_all[1:0];
          last_d     = pick_all[1:0];
          hold_cnt_d = 4'd1;
          grant_d    = 4'b0001 << pick_all[1:0];
        end
      end

      GRANT: begin
        if (!req[owner_q] || (hold_cnt_q == MAX_HOLD_C && pick_others[2])) begin
          if (pick_others[2]) begin
            // Direct handoff: no idle cycle between owners.
            owner_d    = pick_others[1:0];
            last_d     = pick_others[1:0];
            hold_cnt_d = 4'd1;
            grant_d    = 4'b0001 << pick_others[1:0];
          end else begin
            // Released with nobody waiting. Owner (and thus the mux select)
            // keeps its value so the shared output stays stable.
            state_d    = IDLE;
            hold_cnt_d = 4'd0;
            grant_d    = 4'b0000;
          end
        end else if (hold_cnt_q != MAX_HOLD_C) begin
          // Saturating count: without contention the hold is unlimited.
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase

    busy_d = |grant_d;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      last_q     <= 2'd3;
      hold_cnt_q <= 4'd0;
      grant_q    <= 4'b0000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
    end
  end

  // The mux select is the owner register itself: it equals the granted index
  // while busy and holds its previous value while idle.
  assign grant0   = grant_q[0];
  assign grant1   = grant_q[1];
  assign grant2   = grant_q[2];
  assign grant3   = grant_q[3];
  assign address0 = owner_q[0];
  assign address1 = owner_q[1];
  assign busy     = busy_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_arbiter
//
// Self-checking bench for mux_arbiter (MAX_HOLD = 4). Each driven cycle runs a
// behavioural reference model, pushes the expected {grants,address,busy} into
// a scoreboard queue, and pops/compares it one edge later. Directed checks
// against hand-derived constants cover the scenario-level requirements.
// -----------------------------------------------------------------------------
module tb_mux_arbiter;

  localparam int MH = 4;

  logic clk;
  logic reset_n;
  logic req0, req1, req2, req3;
  logic grant0, grant1, grant2, grant3;
  logic address0, address1;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] exp_q[$];

  // Reference model state.
  bit         m_busy;
  int         m_owner;
  int         m_last;
  int         m_hold;

  mux_arbiter #(.MAX_HOLD(MH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req0     (req0),
    .req1     (req1),
    .req2     (req2),
    .req3     (req3),
    .grant0   (grant0),
    .grant1   (grant1),
    .grant2   (grant2),
    .grant3   (grant3),
    .address0 (address0),
    .address1 (address1),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] grants();
    return {grant3, grant2, grant1, grant0};
  endfunction

  function automatic logic [1:0] addr();
    return {address1, address0};
  endfunction

  // Advance the model by one edge with the given inputs; return the
  // expected packed outputs {grant[3:0], address[1:0], busy}.
  function automatic logic [6:0] model_step(input logic rn, input logic [3:0] r);
    int         pick;
    logic [3:0] cand;
    logic [3:0] g;
    pick = -1;
    if (!rn) begin
      m_busy = 0; m_owner = 0; m_last = 3; m_hold = 0;
    end else begin
      cand = r;
      if (m_busy) cand[m_owner] = 1'b0;
      for (int k = 1; k <= 4 && pick < 0; k++)
        if (cand[(m_last + k) % 4]) pick = (m_last + k) % 4;
      if (!m_busy) begin
        if (pick >= 0) begin
          m_busy = 1; m_owner = pick; m_last = pick; m_hold = 1;
        end
      end else if (!r[m_owner] || (m_hold == MH && pick >= 0)) begin
        if (pick >= 0) begin
          m_owner = pick; m_last = pick; m_hold = 1;
        end else begin
          m_busy = 0; m_hold = 0;
        end
      end else if (m_hold < MH) begin
        m_hold++;
      end
    end
    g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    return {g, 2'(m_owner), m_busy};
  endfunction

  // Drive one cycle, push the expectation, wait for the edge, compare.
  task automatic drive(input logic rn, input logic [3:0] r);
    logic [6:0] exp;
    reset_n = rn;
    {req3, req2, req1, req0} = r;
    exp_q.push_back(model_step(rn, r));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("scoreboard", {25'd0, grants(), addr(), busy}, {25'd0, exp});
  endtask

  initial begin
    int         cnt;
    logic [3:0] r;
    logic [3:0] hold_seq [6];

    reset_n = 1'b0;
    {req3, req2, req1, req0} = 4'b0000;
    m_busy = 0; m_owner = 0; m_last = 3; m_hold = 0;

    // Reset with all requests high.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'b1111);
      check("reset_grants", 32'(grants()), 32'h0);
      check("reset_busy",   32'(busy),     32'h0);
      check("reset_addr",   32'(addr()),   32'h0);
    end
    drive(1'b1, 4'b1111);
    check("post_reset_grant0", 32'(grants()), 32'h1);
    check("post_reset_addr",   32'(addr()),   32'h0);
    drive(1'b1, 4'b0000);

    // Single requester for 5 cycles.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i < 5) ? 4'b0100 : 4'b0000);
      if (grant2) cnt++;
    end
    check("single_grant2_cycles", 32'(cnt),    32'd5);
    check("single_idle_addr",     32'(addr()), 32'h2);
    check("single_idle_busy",     32'(busy),   32'h0);

    // Round-robin rotation from reset.
    drive(1'b0, 4'b0000);
    r = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, r);
      check($sformatf("rotation_grant_%0d", i), 32'(grants()), 32'(4'b0001 << i));
      check($sformatf("rotation_busy_%0d", i),  32'(busy),     32'h1);
      r[i] = 1'b0;
    end
    drive(1'b1, 4'b0000);
    check("rotation_idle", 32'(busy), 32'h0);

    // Hold limit: req1 held, req3 rises during req1's second cycle.
    hold_seq = '{4'b0010, 4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, hold_seq[i]);
      if (grant1) cnt++;
    end
    check("hold_grant1_cycles", 32'(cnt),      32'd4);
    check("hold_grant3",        32'(grants()), 32'h8);
    check("hold_addr3",         32'(addr()),   32'h3);
    drive(1'b1, 4'b0010);
    check("hold_return_grant1", 32'(grants()), 32'h2);
    check("hold_return_addr1",  32'(addr()),   32'h1);
    drive(1'b1, 4'b0000);

    // No contention: req0 alone for 20 cycles.
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'b0001);
      if (grant0) cnt++;
    end
    check("nocontention_grant0_cycles", 32'(cnt), 32'd20);
    drive(1'b1, 4'b0000);

    // Mid-grant reset with req3 pending.
    drive(1'b1, 4'b0100);
    check("midreset_pre_grant2", 32'(grants()), 32'h4);
    drive(1'b1, 4'b1100);
    drive(1'b0, 4'b1100);
    check("midreset_grants", 32'(grants()), 32'h0);
    check("midreset_addr",   32'(addr()),   32'h0);
    check("midreset_busy",   32'(busy),     32'h0);
    drive(1'b1, 4'b1100);
    check("midreset_after_grant2", 32'(grants()), 32'h4);
    check("midreset_after_addr",   32'(addr()),   32'h2);
    drive(1'b1, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter that shares the 4:1 single-bit multiplexer between four requesters. It grants one requester at a time and drives the multiplexer's `address1:address0` select lines with the owner's index, so that requester's input reaches `out`. A hold limit stops one requester from monopolising the shared output while others wait.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles for one owner while another request is pending. Legal range 1..15.
- `clk`  in  1  rising-edge clock; all state updates on this edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req0`..`req3`  in  1 each  request from requester i; held high for as long as access is wanted.
- `grant0`..`grant3`  out  1 each  registered, one-hot or all-zero; `granti`=1 means requester i owns the mux.
- `address0`, `address1`  out  1 each  registered mux select; `{address1,address0}` = owner index.
- `busy`  out  1  registered; equals the OR of all grants.

## Operation
- State: FSM {IDLE, GRANT}; 2-bit `owner`; 2-bit `last` (most recent owner); 4-bit `hold_cnt`.
- Reset (`reset_n`=0 at an edge): state=IDLE; all grants=0; busy=0; address=00; owner=0; last=3; hold_cnt=0. Reset has priority over all other activity, including mid-grant; the owner loses its grant at that edge.
- Round-robin pick: scan indices `last+1`, `last+2`, `last+3`, `last+4` (mod 4). Pick the first index with req high.
- IDLE:
  - No req high: stay in IDLE. Address keeps its last value so the mux stays stable.
  - Any req high: go to GRANT with the picked index. Set owner=last=index, address=index, hold_cnt=1.
- GRANT, evaluated each edge with owner o:
  - `req_o`=0 (release):
    - If other reqs are high, hand off at this same edge to the round-robin pick; hold_cnt=1.
    - Otherwise go to IDLE with grants=0.
  - `req_o`=1, hold_cnt==MAX_HOLD, and another req is high: forced handoff at this edge to the pick, which excludes o. hold_cnt=1.
  - `req_o`=1, otherwise: keep the grant. hold_cnt increments, saturating at MAX_HOLD.
- Handoff has no idle cycle. The grant moves directly from one requester to the next, and address changes in the same cycle as the grant.
- Invariants: at most one grant high. When busy=1, address equals the index of the high grant. A grant never goes to a requester whose req was low at the deciding edge.

## Timing
- Request-to-grant latency from IDLE: 1 cycle. A req sampled high at edge N gives grant high after edge N.
- Release latency: 1 cycle. A req sampled low at edge N drops its grant after edge N.
- With no release, an owner holds the grant for exactly MAX_HOLD cycles when others wait. With no contention, the hold is unlimited.
- Simultaneous requests are resolved by the round-robin order relative to `last`. After reset, the order is 0,1,2,3.
- All outputs come straight from registers. No combinational path runs from req to any output.
- Downstream mux gate delays are not part of this block's timing. The clock period must exceed the mux path delay.

## Test plan
- Reset and idle: hold reset_n=0 for 2 cycles with all reqs=1. Required during reset: grants=0000, busy=0, address=00. Release reset. Required one cycle later: grant0=1, address=00.
- Single requester: req2=1 for 5 cycles, then 0. Required: grant2 high for exactly 5 cycles, starting 1 cycle after req2 rises; address=10; then IDLE with address still 10 and busy=0.
- Round-robin rotation: raise req0..req3 together from reset and drop each owner's req one cycle after it is granted. Required grant order: 0,1,2,3. No idle cycle between grants.
- Hold limit: MAX_HOLD=4; req1 held high continuously; req3 rises in cycle 2 of req1's grant. Required: grant1 high for exactly 4 cycles, then grant3 with address=11. Later, grant1 returns after req3 drops.
- No contention: MAX_HOLD=4 with only req0 high for 20 cycles. Required: grant0 stays high for all 20 cycles; hold_cnt saturates at 4 and never forces a handoff.
- Mid-grant reset: grant2 active with req3 pending; assert reset_n=0 for one edge. Required: all grants=0, address=00 after that edge. After reset is released, with req2 and req3 still high, grant2 comes first because last=3 and the scan starts at 0.
